// File: rtl/entrada_handshake.sv
// IN-instruction responder: stalls the CPU, debounces the board button and
// hands one captured switch word to the datapath with a single-cycle strobe.
module entrada_handshake #(
    parameter int DATA_W          = 14,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_req,
    input  logic              botao,
    input  logic [DATA_W-1:0] chaves,
    output logic              stall,
    output logic [DATA_W-1:0] dado,
    output logic              dado_valido,
    output logic              aguardando
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic              sync1_r;
    logic              btn_s_r;
    logic              btn_db_r;
    logic              btn_db_prev_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              press_evt_s;
    logic [DATA_W-1:0] dado_r;
    logic              dado_valido_r;
    logic              aguardando_r;

    // Two-flop synchronizer, debounce counter and press edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r       <= 1'b0;
            btn_s_r       <= 1'b0;
            btn_db_r      <= 1'b0;
            btn_db_prev_r <= 1'b0;
            cnt_r         <= '0;
        end else begin
            sync1_r       <= botao;
            btn_s_r       <= sync1_r;
            btn_db_prev_r <= btn_db_r;
            if (btn_s_r != btn_db_r) begin
                if (cnt_r == CNT_LAST) begin
                    btn_db_r <= ~btn_db_r;
                    cnt_r    <= '0;
                end else begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign press_evt_s = btn_db_r & ~btn_db_prev_r;

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a dropped request in WAIT aborts without a strobe.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_req) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (!in_req) begin
                    next_state_s = IDLE;
                end else if (press_evt_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Stall is combinational so the CPU freezes in the decode cycle itself.
    always_comb begin
        stall = 1'b0;
        case (state_r)
            IDLE:    stall = in_req;
            WAIT:    stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // Registered outputs, loaded from the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            dado_r        <= '0;
            dado_valido_r <= 1'b0;
            aguardando_r  <= 1'b0;
        end else begin
            dado_valido_r <= (next_state_s == DONE);
            aguardando_r  <= (next_state_s == WAIT);
            if ((state_r == WAIT) && (next_state_s == DONE)) begin
                dado_r <= chaves;
            end else begin
                dado_r <= dado_r;
            end
        end
    end

    assign dado        = dado_r;
    assign dado_valido = dado_valido_r;
    assign aguardando  = aguardando_r;

endmodule

// File: tb/tb_entrada_handshake.sv
// Directed, cycle-exact bench for entrada_handshake with a short debounce window.
module tb_entrada_handshake;

    localparam int DW = 14;

    logic          clk;
    logic          reset;
    logic          in_req;
    logic          botao;
    logic [DW-1:0] chaves;
    logic          stall;
    logic [DW-1:0] dado;
    logic          dado_valido;
    logic          aguardando;

    int n_cmp;
    int n_err;

    typedef struct {
        logic          rst;
        logic          req;
        logic          b;
        logic [DW-1:0] ch;
        logic          e_stall;
        logic [DW-1:0] e_dado;
        logic          e_valid;
        logic          e_ag;
    } vec_t;

    vec_t tbl [13];

    entrada_handshake #(
        .DATA_W(DW),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_req(in_req),
        .botao(botao),
        .chaves(chaves),
        .stall(stall),
        .dado(dado),
        .dado_valido(dado_valido),
        .aguardando(aguardando)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic q, input logic b,
                                input logic [DW-1:0] ch, input logic es,
                                input logic [DW-1:0] ed, input logic ev,
                                input logic ea);
        vec_t v;
        v.rst = r; v.req = q; v.b = b; v.ch = ch;
        v.e_stall = es; v.e_dado = ed; v.e_valid = ev; v.e_ag = ea;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h, expected %h (t=%0t)", nm, fld, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, advance past the edge.
    task automatic cyc(input logic r, input logic q, input logic b,
                       input logic [DW-1:0] ch, input logic es,
                       input logic [DW-1:0] ed, input logic ev,
                       input logic ea, input string nm);
        reset = r; in_req = q; botao = b; chaves = ch;
        @(negedge clk);
        chk(nm, "stall", {{(DW-1){1'b0}}, stall}, {{(DW-1){1'b0}}, es});
        chk(nm, "dado", dado, ed);
        chk(nm, "dado_valido", {{(DW-1){1'b0}}, dado_valido}, {{(DW-1){1'b0}}, ev});
        chk(nm, "aguardando", {{(DW-1){1'b0}}, aguardando}, {{(DW-1){1'b0}}, ea});
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; in_req = 1'b0; botao = 1'b0; chaves = 14'h0000;

        // Second reset cycle, then basic capture: button rises with the request.
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 14'h01A5, 1'b0, 14'h0000, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 14'h01A5, 1'b1, 14'h0000, 1'b0, 1'b0);
        for (int i = 3; i <= 8; i++)
            tbl[i] = mk(1'b0, 1'b1, 1'b1, 14'h01A5, 1'b1, 14'h0000, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 1'b1, 1'b1, 14'h01A5, 1'b0, 14'h01A5, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 14'h01A5, 1'b0, 14'h01A5, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 14'h01A5, 1'b0, 14'h01A5, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 14'h01A5, 1'b0, 14'h01A5, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++)
            cyc(tbl[i].rst, tbl[i].req, tbl[i].b, tbl[i].ch, tbl[i].e_stall,
                tbl[i].e_dado, tbl[i].e_valid, tbl[i].e_ag, $sformatf("tbl%0d", i));

        // Held button across the next IN: no capture; switches change meanwhile.
        cyc(1'b0, 1'b1, 1'b1, 14'h3FFF, 1'b1, 14'h01A5, 1'b0, 1'b0, "held_enter");
        for (int i = 0; i < 7; i++)
            cyc(1'b0, 1'b1, 1'b1, 14'h3FFF, 1'b1, 14'h01A5, 1'b0, 1'b1, "held_wait");
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b1, 1'b0, 14'h3FFF, 1'b1, 14'h01A5, 1'b0, 1'b1, "held_release");
        for (int i = 0; i < 7; i++)
            cyc(1'b0, 1'b1, 1'b1, 14'h3FFF, 1'b1, 14'h01A5, 1'b0, 1'b1, "held_press");
        cyc(1'b0, 1'b1, 1'b1, 14'h3FFF, 1'b0, 14'h3FFF, 1'b1, 1'b0, "held_capture");
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b0, 1'b0, 14'h3FFF, 1'b0, 14'h3FFF, 1'b0, 1'b0, "held_after");

        // Bounce rejection: two-cycle pulses never survive the debounce window.
        cyc(1'b0, 1'b1, 1'b1, 14'h0AAA, 1'b1, 14'h3FFF, 1'b0, 1'b0, "bounce_enter");
        for (int i = 1; i < 12; i++)
            cyc(1'b0, 1'b1, (((i / 2) % 2) == 0) ? 1'b1 : 1'b0, 14'h0AAA,
                1'b1, 14'h3FFF, 1'b0, 1'b1, "bounce");
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b1, 1'b0, 14'h0AAA, 1'b1, 14'h3FFF, 1'b0, 1'b1, "bounce_quiet");

        // Request dropped in WAIT aborts; a press made in IDLE is not remembered.
        cyc(1'b0, 1'b0, 1'b0, 14'h0AAA, 1'b1, 14'h3FFF, 1'b0, 1'b1, "abort");
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b0, 1'b1, 14'h0AAA, 1'b0, 14'h3FFF, 1'b0, 1'b0, "idle_press");
        cyc(1'b0, 1'b1, 1'b1, 14'h0AAA, 1'b1, 14'h3FFF, 1'b0, 1'b0, "late_enter");
        for (int i = 0; i < 9; i++)
            cyc(1'b0, 1'b1, 1'b1, 14'h0AAA, 1'b1, 14'h3FFF, 1'b0, 1'b1, "late_wait");

        // Reset mid-WAIT with the button held; the held button becomes a fresh press.
        cyc(1'b1, 1'b0, 1'b1, 14'h1234, 1'b1, 14'h3FFF, 1'b0, 1'b1, "rst_wait");
        cyc(1'b0, 1'b0, 1'b1, 14'h1234, 1'b0, 14'h0000, 1'b0, 1'b0, "rst_after");
        cyc(1'b0, 1'b1, 1'b1, 14'h1234, 1'b1, 14'h0000, 1'b0, 1'b0, "rst_enter");
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b1, 1'b1, 14'h1234, 1'b1, 14'h0000, 1'b0, 1'b1, "rst_wait2");
        cyc(1'b0, 1'b1, 1'b1, 14'h1234, 1'b0, 14'h1234, 1'b1, 1'b0, "rst_capture");
        cyc(1'b0, 1'b0, 1'b0, 14'h1234, 1'b0, 14'h1234, 1'b0, 1'b0, "rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
